// File: rtl/fp_norm_pkg.sv
// Shared types and helpers for the fp_norm_seq mantissa normalizer.
package fp_norm_pkg;

   localparam int MANT_W    = 32;
   localparam int EXP_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Leading-zero count of one nibble; an all-zero nibble reports 3.
   function automatic logic [1:0] lzc4(input logic [3:0] n);
      logic [1:0] r;
      casez (n)
         4'b1???: r = 2'd0;
         4'b01??: r = 2'd1;
         4'b001?: r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fp_norm_seq_if.sv
// Valid/ready operand and result channels of the mantissa normalizer.
interface fp_norm_seq_if #(
   parameter int EXP_W = fp_norm_pkg::EXP_W_DEF
);
   import fp_norm_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] in_mant;
   logic [EXP_W-1:0]  in_exp;
   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] out_mant;
   logic [EXP_W-1:0]  out_exp;
   logic              out_zero;
   logic              out_uflow;
   logic              busy;

   modport master (
      output in_valid, in_mant, in_exp, out_ready,
      input  in_ready, out_valid, out_mant, out_exp,
      input  out_zero, out_uflow, busy
   );

   modport slave (
      input  in_valid, in_mant, in_exp, out_ready,
      output in_ready, out_valid, out_mant, out_exp,
      output out_zero, out_uflow, busy
   );

endinterface

// File: rtl/ls_L.sv
// 32-bit logical left shifter, five binary-weighted stages.
module ls_L (
   input  logic [31:0] indata,
   input  logic [4:0]  shift,
   output logic [31:0] outdata
);

   logic [31:0] s0, s1, s2, s3;

   always_comb begin
      s0      = shift[0] ? {indata[30:0], 1'b0}  : indata;
      s1      = shift[1] ? {s0[29:0], 2'b0}      : s0;
      s2      = shift[2] ? {s1[27:0], 4'b0}      : s1;
      s3      = shift[3] ? {s2[23:0], 8'b0}      : s2;
      outdata = shift[4] ? {s3[15:0], 16'b0}     : s3;
   end

endmodule

// File: rtl/fp_norm_seq.sv
// Multi-cycle mantissa normalizer: nibble-serial leading-zero scan,
// then one left shift of the original mantissa with exponent clamping.
module fp_norm_seq #(
   parameter int EXP_W  = fp_norm_pkg::EXP_W_DEF,
   parameter int MANT_W = fp_norm_pkg::MANT_W
) (
   input  logic         clk,
   input  logic         rst,
   fp_norm_seq_if.slave io
);
   import fp_norm_pkg::*;

   if (MANT_W != 32) begin : g_mant_chk
      $error("fp_norm_seq: MANT_W must be 32");
   end
   if (EXP_W < 5) begin : g_exp_chk
      $error("fp_norm_seq: EXP_W must be at least 5");
   end

   state_t            state_q, state_d;
   logic [31:0]       scan_q, scan_d;
   logic [31:0]       mant_q, mant_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [2:0]        nib_cnt_q, nib_cnt_d;
   logic [4:0]        lz_q, lz_d;
   logic [31:0]       omant_q, omant_d;
   logic [EXP_W-1:0]  oexp_q, oexp_d;
   logic              zero_q, zero_d;
   logic              uflow_q, uflow_d;

   logic [EXP_W:0]    lz_x;
   logic [EXP_W-1:0]  exp_sub;
   logic              uf;
   logic [4:0]        shamt;
   logic [31:0]       shl;

   // Compare in EXP_W+1 bits so a large lz can never wrap into out_exp.
   always_comb begin
      lz_x    = (EXP_W + 1)'(lz_q);
      uf      = lz_x > {1'b0, exp_q};
      exp_sub = exp_q - lz_x[EXP_W-1:0];
      shamt   = uf ? exp_q[4:0] : lz_q;
   end

   ls_L u_ls (
      .indata  (mant_q),
      .shift   (shamt),
      .outdata (shl)
   );

   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      mant_d    = mant_q;
      exp_d     = exp_q;
      nib_cnt_d = nib_cnt_q;
      lz_d      = lz_q;
      omant_d   = omant_q;
      oexp_d    = oexp_q;
      zero_d    = zero_q;
      uflow_d   = uflow_q;
      unique case (state_q)
         ST_IDLE: begin
            if (io.in_valid) begin
               mant_d    = io.in_mant;
               scan_d    = io.in_mant;
               exp_d     = io.in_exp;
               nib_cnt_d = 3'd0;
               if (io.in_mant == 32'd0) begin
                  omant_d = 32'd0;
                  oexp_d  = '0;
                  zero_d  = 1'b1;
                  uflow_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (scan_q[31:28] == 4'd0) begin
               scan_d    = {scan_q[27:0], 4'd0};
               nib_cnt_d = nib_cnt_q + 3'd1;
            end else begin
               lz_d    = {nib_cnt_q, 2'b00} + {3'b000, lzc4(scan_q[31:28])};
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            omant_d = shl;
            oexp_d  = uf ? '0 : exp_sub;
            uflow_d = uf;
            zero_d  = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (io.out_ready) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         scan_q    <= '0;
         mant_q    <= '0;
         exp_q     <= '0;
         nib_cnt_q <= '0;
         lz_q      <= '0;
         omant_q   <= '0;
         oexp_q    <= '0;
         zero_q    <= 1'b0;
         uflow_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         scan_q    <= scan_d;
         mant_q    <= mant_d;
         exp_q     <= exp_d;
         nib_cnt_q <= nib_cnt_d;
         lz_q      <= lz_d;
         omant_q   <= omant_d;
         oexp_q    <= oexp_d;
         zero_q    <= zero_d;
         uflow_q   <= uflow_d;
      end
   end

   assign io.in_ready  = (state_q == ST_IDLE);
   assign io.busy      = (state_q != ST_IDLE);
   assign io.out_valid = (state_q == ST_DONE);
   assign io.out_mant  = omant_q;
   assign io.out_exp   = oexp_q;
   assign io.out_zero  = zero_q;
   assign io.out_uflow = uflow_q;

endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed self-checking bench for fp_norm_seq.
module tb_fp_norm_seq;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fp_norm_seq_if #(.EXP_W(8)) bus ();

   fp_norm_seq #(.EXP_W(8), .MANT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   // Present one operand from IDLE; return edges from accept to out_valid.
   task automatic start_op(input logic [31:0] m, input logic [7:0] e,
                           output int lat);
      bus.in_mant  = m;
      bus.in_exp   = e;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_mant  = 32'hdead_beef;
      bus.in_exp   = 8'hff;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_mant = '0;
      bus.in_exp = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hs: rdy=%b busy=%b ov=%b want 1 0 0",
                  bus.in_ready, bus.busy, bus.out_valid);
      end
      tests++;
      if (bus.out_mant !== 32'd0 || bus.out_exp !== 8'd0 ||
          bus.out_zero !== 1'b0 || bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_out: mant=%h exp=%0d z=%b u=%b want 0 0 0 0",
                  bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow);
      end
   endtask

   task automatic test_normalized();
      int lat;
      start_op(32'h8000_0000, 8'd10, lat);
      tests++;
      if (lat !== 2) begin
         fails++;
         $display("FAIL norm_lat: got %0d want 2", lat);
      end
      tests++;
      if (bus.out_mant !== 32'h8000_0000 || bus.out_exp !== 8'd10 ||
          bus.out_uflow !== 1'b0 || bus.out_zero !== 1'b0) begin
         fails++;
         $display("FAIL norm_res: mant=%h exp=%0d u=%b z=%b want 80000000 10 0 0",
                  bus.out_mant, bus.out_exp, bus.out_uflow, bus.out_zero);
      end
      consume();
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL norm_release: rdy=%b ov=%b want 1 0",
                  bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_lz();
      int lat;
      start_op(32'h0001_0000, 8'd100, lat);
      tests++;
      if (lat !== 5 || bus.out_mant !== 32'h8000_0000 || bus.out_exp !== 8'd85 ||
          bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL lz15: lat=%0d mant=%h exp=%0d u=%b want 5 80000000 85 0",
                  lat, bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      consume();
      start_op(32'h0000_0001, 8'd200, lat);
      tests++;
      if (lat !== 9 || bus.out_mant !== 32'h8000_0000 || bus.out_exp !== 8'd169 ||
          bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL lz31: lat=%0d mant=%h exp=%0d u=%b want 9 80000000 169 0",
                  lat, bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      consume();
      start_op(32'h0340_0000, 8'd50, lat);
      tests++;
      if (lat !== 3 || bus.out_mant !== 32'hd000_0000 || bus.out_exp !== 8'd44) begin
         fails++;
         $display("FAIL lz6: lat=%0d mant=%h exp=%0d want 3 d0000000 44",
                  lat, bus.out_mant, bus.out_exp);
      end
      consume();
   endtask

   task automatic test_uflow();
      int lat;
      start_op(32'h0000_1000, 8'd5, lat);
      tests++;
      if (lat !== 6 || bus.out_mant !== 32'h0002_0000 || bus.out_exp !== 8'd0 ||
          bus.out_uflow !== 1'b1) begin
         fails++;
         $display("FAIL uflow: lat=%0d mant=%h exp=%0d u=%b want 6 00020000 0 1",
                  lat, bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      consume();
      start_op(32'h0000_1000, 8'd19, lat);
      tests++;
      if (bus.out_mant !== 32'h8000_0000 || bus.out_exp !== 8'd0 ||
          bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL uflow_edge: mant=%h exp=%0d u=%b want 80000000 0 0",
                  bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      consume();
   endtask

   task automatic test_zero_hold();
      int lat;
      logic ok;
      start_op(32'h0000_0000, 8'd77, lat);
      tests++;
      if (lat !== 0 || bus.out_zero !== 1'b1 || bus.out_mant !== 32'd0 ||
          bus.out_exp !== 8'd0 || bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL zero: lat=%0d z=%b mant=%h exp=%0d u=%b want 0 1 0 0 0",
                  lat, bus.out_zero, bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.in_mant  = 32'h1234_5678;
         bus.in_exp   = 8'd9;
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             bus.out_zero !== 1'b1 || bus.out_mant !== 32'd0 ||
             bus.out_exp !== 8'd0)
            ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      tests++;
      if (ok !== 1'b1) begin
         fails++;
         $display("FAIL zero_hold: stable=%b want 1", ok);
      end
      consume();
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL zero_release: rdy=%b ov=%b want 1 0",
                  bus.in_ready, bus.out_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.out_zero !== 1'b1) begin
         fails++;
         $display("FAIL zero_ignored: busy=%b z=%b want 0 1",
                  bus.busy, bus.out_zero);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      start_op(32'h0000_1000, 8'd5, lat);
      consume();
      bus.in_mant  = 32'h0000_0001;
      bus.in_exp   = 8'd200;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL midrst_scan: busy=%b ov=%b want 1 0",
                  bus.busy, bus.out_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.out_mant !== 32'd0 || bus.out_exp !== 8'd0 ||
          bus.out_zero !== 1'b0 || bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL midrst_out: rdy=%b busy=%b ov=%b mant=%h exp=%0d z=%b u=%b",
                  bus.in_ready, bus.busy, bus.out_valid, bus.out_mant,
                  bus.out_exp, bus.out_zero, bus.out_uflow);
      end
      start_op(32'h8000_0000, 8'd10, lat);
      tests++;
      if (lat !== 2 || bus.out_mant !== 32'h8000_0000 || bus.out_exp !== 8'd10 ||
          bus.out_uflow !== 1'b0) begin
         fails++;
         $display("FAIL midrst_next: lat=%0d mant=%h exp=%0d u=%b want 2 80000000 10 0",
                  lat, bus.out_mant, bus.out_exp, bus.out_uflow);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_normalized();
      test_lz();
      test_uflow();
      test_zero_hold();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
